// File: rtl/sha256_padder.sv
// sha256_padder
//   Front end of the SHA-256 transform. Accepts a byte-granular message as
//   32-bit big-endian words and emits 512-bit chunks (16 words) with the
//   standard padding: a 0x80 marker byte, zero fill, and the 64-bit
//   big-endian message bit length. An extra chunk is emitted when the length
//   field does not fit behind the marker. The final chunk of each message is
//   flagged with chunk_last.
//
//   State table:
//     FILL | accepting message words into the chunk buffer
//     PAD  | writing one padding/length word per cycle until word 15
//     SEND | presenting the buffered chunk until chunk_data_rdy
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   msg_vld/rdy    input word handshake
//   msg_data       message word, byte 0 in [31:24]
//   msg_last       final word of the message
//   msg_bytes      valid bytes in the word (0..4)
//   chunk_data_vld/rdy  output chunk handshake
//   chunk_data     16 words, chunk_data[0] is the first word
//   chunk_last     final chunk of the message (qualified by chunk_data_vld)
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_vld,
  output logic              msg_rdy,
  input  logic [31:0]       msg_data,
  input  logic              msg_last,
  input  logic [2:0]        msg_bytes,
  output logic              chunk_data_vld,
  input  logic              chunk_data_rdy,
  output logic [15:0][31:0] chunk_data,
  output logic              chunk_last
);

  typedef enum logic [1:0] {FILL, PAD, SEND} state_t;

  state_t            state_q, state_d;
  logic [15:0][31:0] buffer;
  logic [3:0]        widx;
  logic [LEN_W-1:0]  bitlen;
  logic              pend80;
  logic              need_extra;
  logic              fit;
  logic              last_q;

  logic              accept;
  logic [2:0]        eff_bytes;
  logic [31:0]       word_in;
  logic [63:0]       len64;
  logic [31:0]       pad_word;
  logic              fit_new;

  assign accept = msg_vld && (state_q == FILL);

  // Short words are only legal on the final word; otherwise treat as full.
  assign eff_bytes = (!msg_last || (msg_bytes > 3'd4)) ? 3'd4 : msg_bytes;

  // Invalid bytes are zeroed; a short final word also carries the marker.
  always_comb begin
    word_in = msg_data;
    case (eff_bytes)
      3'd0:    word_in = 32'h8000_0000;
      3'd1:    word_in = {msg_data[31:24], 24'h80_0000};
      3'd2:    word_in = {msg_data[31:16], 16'h8000};
      3'd3:    word_in = {msg_data[31:8], 8'h80};
      default: word_in = msg_data;
    endcase
  end

  // The length field fits if the word after the marker is at most 14.
  // A full final word pushes the marker itself into the next word.
  assign fit_new = (eff_bytes == 3'd4) ? (widx <= 4'd12) : (widx <= 4'd13);

  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = bitlen;
  end

  always_comb begin
    pad_word = '0;
    if (pend80)
      pad_word = 32'h8000_0000;
    else if (fit && (widx == 4'd14))
      pad_word = len64[63:32];
    else if (fit && (widx == 4'd15))
      pad_word = len64[31:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (widx == 4'd15)
            state_d = SEND;
          else if (msg_last)
            state_d = PAD;
        end
      end
      PAD: begin
        if (widx == 4'd15)
          state_d = SEND;
      end
      SEND: begin
        if (chunk_data_rdy)
          state_d = (need_extra || pend80) ? PAD : FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign msg_rdy        = (state_q == FILL);
  assign chunk_data_vld = (state_q == SEND);
  assign chunk_data     = (state_q == SEND) ? buffer : '0;
  assign chunk_last     = (state_q == SEND) && last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= FILL;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer     <= '0;
      widx       <= '0;
      bitlen     <= '0;
      pend80     <= 1'b0;
      need_extra <= 1'b0;
      fit        <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            buffer[widx] <= word_in;
            bitlen       <= bitlen + LEN_W'({eff_bytes, 3'b000});
            widx         <= widx + 4'd1;
            last_q       <= 1'b0;
            if (msg_last) begin
              pend80     <= (eff_bytes == 3'd4);
              fit        <= fit_new;
              need_extra <= !fit_new;
            end
          end
        end
        PAD: begin
          buffer[widx] <= pad_word;
          pend80       <= 1'b0;
          widx         <= widx + 4'd1;
          if (widx == 4'd15)
            last_q <= fit;
        end
        SEND: begin
          if (chunk_data_rdy) begin
            widx   <= '0;
            buffer <= '0;
            if (need_extra || pend80) begin
              // Follow-on chunk always has room for the length field.
              need_extra <= 1'b0;
              fit        <= 1'b1;
            end else if (last_q) begin
              bitlen <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
module tb_sha256_padder;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              msg_vld = 1'b0;
  logic              msg_rdy;
  logic [31:0]       msg_data = '0;
  logic              msg_last = 1'b0;
  logic [2:0]        msg_bytes = '0;
  logic              chunk_data_vld;
  logic              chunk_data_rdy = 1'b0;
  logic [15:0][31:0] chunk_data;
  logic              chunk_last;

  sha256_padder #(.LEN_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .msg_vld        (msg_vld),
    .msg_rdy        (msg_rdy),
    .msg_data       (msg_data),
    .msg_last       (msg_last),
    .msg_bytes      (msg_bytes),
    .chunk_data_vld (chunk_data_vld),
    .chunk_data_rdy (chunk_data_rdy),
    .chunk_data     (chunk_data),
    .chunk_last     (chunk_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0][31:0] d;
    logic              last;
  } chunk_t;

  int     nvec = 0;
  int     nerr = 0;
  chunk_t exp_q[$];
  chunk_t seen;
  bit     drv_done;
  int     rdy_pct = 100;
  int     gap_pct = 0;

  // Reference: byte-level padding, then slice into 64-byte chunks.
  function automatic void build_exp(input logic [7:0] m[$]);
    logic [7:0]  p[$];
    logic [63:0] len;
    chunk_t      c;
    int          nch;
    p   = m;
    len = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
    nch = p.size() / 64;
    for (int k = 0; k < nch; k++) begin
      for (int w = 0; w < 16; w++)
        c.d[w] = {p[64*k+4*w], p[64*k+4*w+1], p[64*k+4*w+2], p[64*k+4*w+3]};
      c.last = (k == nch - 1);
      exp_q.push_back(c);
    end
  endfunction

  function automatic void rand_msg(input int n, output logic [7:0] m[$]);
    m = {};
    for (int i = 0; i < n; i++) m.push_back(8'($urandom));
  endfunction

  task automatic drive_msg(input logic [7:0] m[$]);
    int         n;
    int         nw;
    int         nb;
    int         t;
    logic       ok;
    logic [31:0] d;
    n  = m.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      nb = (w < nw - 1) ? 4 : (n - 4 * (nw - 1));
      d  = $urandom;
      for (int b = 0; b < 4; b++)
        if (b < nb) d[31-8*b -: 8] = m[4*w+b];
      while ($urandom_range(99) < gap_pct) begin
        @(negedge clk);
        msg_vld = 1'b0;
      end
      @(negedge clk);
      msg_vld   = 1'b1;
      msg_data  = d;
      msg_bytes = 3'(nb);
      msg_last  = (w == nw - 1);
      t = 0;
      forever begin
        ok = msg_rdy;
        @(posedge clk);
        if (ok) break;
        @(negedge clk);
        t++;
        if (t > 3000) begin
          nvec++;
          nerr++;
          $display("FAIL msg_accept_timeout: word %0d still waiting after %0d cycles, required msg_rdy=1", w, t);
          msg_vld = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    msg_vld  = 1'b0;
    msg_last = 1'b0;
  endtask

  task automatic monitor(input int budget);
    int                t;
    logic              held;
    logic [15:0][31:0] hold;
    chunk_t            c;
    t    = 0;
    held = 1'b0;
    hold = '0;
    while (!(drv_done && exp_q.size() == 0)) begin
      @(negedge clk);
      t++;
      if (held) begin
        nvec++;
        if (chunk_data_vld !== 1'b1 || chunk_data !== hold) begin
          nerr++;
          $display("FAIL stall_stable: vld=%b data=%h required vld=1 data=%h", chunk_data_vld, chunk_data, hold);
        end
      end
      chunk_data_rdy = ($urandom_range(99) < rdy_pct);
      held = 1'b0;
      if (chunk_data_vld === 1'b1) begin
        if (!chunk_data_rdy) begin
          held = 1'b1;
          hold = chunk_data;
        end else if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_chunk: got data=%h required no chunk", chunk_data);
        end else begin
          c = exp_q.pop_front();
          nvec++;
          if (chunk_data !== c.d) begin
            nerr++;
            $display("FAIL chunk_data: got %h required %h", chunk_data, c.d);
          end
          nvec++;
          if (chunk_last !== c.last) begin
            nerr++;
            $display("FAIL chunk_last: got %b required %b", chunk_last, c.last);
          end
          seen.d    = chunk_data;
          seen.last = chunk_last;
        end
      end
      if (t > budget) begin
        nvec++;
        nerr++;
        $display("FAIL chunk_timeout: %0d chunks outstanding after %0d cycles, required 0", exp_q.size(), t);
        exp_q = {};
        break;
      end
    end
    @(posedge clk);
    #1;
    chunk_data_rdy = 1'b0;
  endtask

  task automatic run_msg(input logic [7:0] m[$]);
    build_exp(m);
    drv_done = 1'b0;
    fork
      begin
        drive_msg(m);
        drv_done = 1'b1;
      end
      monitor(4000);
    join
  endtask

  task automatic test_reset();
    nvec++;
    if (msg_rdy !== 1'b1) begin
      nerr++;
      $display("FAIL reset_msg_rdy: got %b required 1", msg_rdy);
    end
    nvec++;
    if (chunk_data_vld !== 1'b0) begin
      nerr++;
      $display("FAIL reset_vld: got %b required 0", chunk_data_vld);
    end
    nvec++;
    if (chunk_last !== 1'b0) begin
      nerr++;
      $display("FAIL reset_last: got %b required 0", chunk_last);
    end
    nvec++;
    if (chunk_data !== '0) begin
      nerr++;
      $display("FAIL reset_data: got %h required 0", chunk_data);
    end
  endtask

  task automatic test_abc();
    logic [7:0] m[$];
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m);
    nvec++;
    if (seen.d[0] !== 32'h6162_6380 || seen.d[15] !== 32'h0000_0018 || seen.last !== 1'b1) begin
      nerr++;
      $display("FAIL abc_literal: got w0=%h w15=%h last=%b required w0=61626380 w15=00000018 last=1",
               seen.d[0], seen.d[15], seen.last);
    end
  endtask

  task automatic test_empty();
    logic [7:0] m[$];
    m = {};
    run_msg(m);
    nvec++;
    if (seen.d[0] !== 32'h8000_0000 || seen.d[15] !== 32'h0 || seen.last !== 1'b1) begin
      nerr++;
      $display("FAIL empty_literal: got w0=%h w15=%h last=%b required w0=80000000 w15=0 last=1",
               seen.d[0], seen.d[15], seen.last);
    end
  endtask

  task automatic test_extra_chunk();
    logic [7:0] m[$];
    rand_msg(56, m);
    run_msg(m);
    nvec++;
    if (seen.d[0] !== 32'h0 || seen.d[14] !== 32'h0 || seen.d[15] !== 32'h0000_01C0) begin
      nerr++;
      $display("FAIL len56_literal: got w0=%h w14=%h w15=%h required 0 0 000001c0",
               seen.d[0], seen.d[14], seen.d[15]);
    end
    rand_msg(64, m);
    run_msg(m);
    nvec++;
    if (seen.d[0] !== 32'h8000_0000 || seen.d[15] !== 32'h0000_0200) begin
      nerr++;
      $display("FAIL len64_literal: got w0=%h w15=%h required 80000000 00000200",
               seen.d[0], seen.d[15]);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] m[$];
    rdy_pct = 100;
    gap_pct = 0;
    for (int n = 50; n <= 67; n++) begin
      rand_msg(n, m);
      run_msg(m);
    end
    for (int n = 118; n <= 129; n++) begin
      rand_msg(n, m);
      run_msg(m);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] m[$];
    chunk_t     c;
    int         t;
    m = '{8'h61, 8'h62, 8'h63};
    build_exp(m);
    c = exp_q.pop_front();
    chunk_data_rdy = 1'b0;
    drive_msg(m);
    t = 0;
    while (chunk_data_vld !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    nvec++;
    if (chunk_data_vld !== 1'b1) begin
      nerr++;
      $display("FAIL bp_wait_vld: got %b required 1", chunk_data_vld);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nvec++;
      if (chunk_data_vld !== 1'b1 || chunk_data !== c.d || msg_rdy !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold: cycle %0d vld=%b msg_rdy=%b data=%h required vld=1 msg_rdy=0 data=%h",
                 i, chunk_data_vld, msg_rdy, chunk_data, c.d);
      end
    end
    chunk_data_rdy = 1'b1;
    @(posedge clk);
    #1;
    chunk_data_rdy = 1'b0;
    nvec++;
    if (chunk_data_vld !== 1'b0 || msg_rdy !== 1'b1) begin
      nerr++;
      $display("FAIL bp_single_handshake: vld=%b msg_rdy=%b required vld=0 msg_rdy=1", chunk_data_vld, msg_rdy);
    end
  endtask

  task automatic test_reset_mid_pad();
    logic [7:0] m[$];
    @(negedge clk);
    msg_vld   = 1'b1;
    msg_data  = 32'h6162_6300;
    msg_bytes = 3'd3;
    msg_last  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    msg_vld  = 1'b0;
    msg_last = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if (msg_rdy !== 1'b0) begin
      nerr++;
      $display("FAIL mid_in_pad: msg_rdy=%b required 0", msg_rdy);
    end
    #2;
    rst = 1'b0;
    #1;
    nvec++;
    if (chunk_data_vld !== 1'b0 || msg_rdy !== 1'b1 || chunk_data !== '0) begin
      nerr++;
      $display("FAIL async_reset: vld=%b msg_rdy=%b data=%h required vld=0 msg_rdy=1 data=0",
               chunk_data_vld, msg_rdy, chunk_data);
    end
    @(negedge clk);
    rst = 1'b1;
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m);
    nvec++;
    if (seen.d[0] !== 32'h6162_6380 || seen.d[1] !== 32'h0 || seen.d[15] !== 32'h0000_0018) begin
      nerr++;
      $display("FAIL post_reset_abc: got w0=%h w1=%h w15=%h required 61626380 0 00000018",
               seen.d[0], seen.d[1], seen.d[15]);
    end
  endtask

  task automatic test_random();
    logic [7:0] m[$];
    rdy_pct  = 60;
    gap_pct  = 25;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          rand_msg($urandom_range(0, 140), m);
          build_exp(m);
          drive_msg(m);
        end
        drv_done = 1'b1;
      end
      monitor(30000);
    join
    rdy_pct = 100;
    gap_pct = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_abc();
    test_empty();
    test_extra_chunk();
    test_boundaries();
    test_backpressure();
    test_reset_mid_pad();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
